// File: rtl/and_gate_self_test.sv
// Built-in self-test for a 2-input AND gate: walks the four truth-table vectors,
// samples the gate output after each hold window and reports pass/err_count/fail_vec.
module and_gate_self_test #(
  parameter int unsigned HOLD_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       s_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       err_q, err_d;
  logic [3:0]       fail_q, fail_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             mismatch;

  assign mismatch = s_in != (idx_q[1] & idx_q[0]);

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = 2'd0;
          cnt_d   = '0;
          err_d   = 3'd0;
          fail_d  = 4'd0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          if (mismatch) begin
            err_d         = err_q + 3'd1;
            fail_d[idx_q] = 1'b1;
          end
          cnt_d = '0;
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
          end else begin
            // Final comparison lands in err_d on the same edge, so pass sees it
            state_d = DONE;
            pass_d  = (err_d == 3'd0);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    a_d    = busy_d & idx_d[1];
    b_d    = busy_d & idx_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_and_gate_self_test.sv
// Bench for and_gate_self_test: a gate model with selectable faults, directed runs,
// and a scoreboard monitor that checks results whenever done rises.
module tb_and_gate_self_test;

  localparam int unsigned HOLD = 4;
  localparam int unsigned RUN_LEN = 4 * HOLD;

  localparam logic [1:0] M_AND = 2'd0;
  localparam logic [1:0] M_ZERO = 2'd1;
  localparam logic [1:0] M_ONE = 2'd2;
  localparam logic [1:0] M_OR = 2'd3;

  typedef struct packed {
    logic       pass;
    logic [2:0] err;
    logic [3:0] fail;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       a_out, b_out, s_in;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic [1:0] mode;

  int n_cmp = 0;
  int n_fail = 0;
  exp_t sb[$];

  and_gate_self_test #(.HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_out     (a_out),
    .b_out     (b_out),
    .s_in      (s_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  always #5 clk = ~clk;

  // Gate under test, with stuck-at and wrong-function variants
  always_comb begin
    case (mode)
      M_AND:   s_in = a_out & b_out;
      M_ZERO:  s_in = 1'b0;
      M_ONE:   s_in = 1'b1;
      default: s_in = a_out | b_out;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pop an expectation on every rising done
  initial begin
    logic done_seen;
    exp_t e;
    done_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && !done_seen) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_pass", 32'(pass), 32'(e.pass));
          check("sb_err_count", 32'(err_count), 32'(e.err));
          check("sb_fail_vec", 32'(fail_vec), 32'(e.fail));
        end
      end
      done_seen = (done === 1'b1);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_a_b"}, 32'({a_out, b_out}), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_err"}, 32'(err_count), 32'd0);
    check({tag, "_fail"}, 32'(fail_vec), 32'd0);
  endtask

  // One full run with cycle-accurate vector/busy/done checks
  task automatic do_run(input logic [1:0] m, input exp_t e, input bit hold_start);
    mode = m;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1;
    for (int j = 0; j < int'(RUN_LEN); j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j == 0 && !hold_start) start = 1'b0;
      check("run_vec", 32'({a_out, b_out}), 32'(j / int'(HOLD)));
      check("run_busy", 32'(busy), 32'd1);
      check("run_done", 32'(done), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    check("end_busy", 32'(busy), 32'd0);
    check("end_done", 32'(done), 32'd1);
    check("end_vec", 32'({a_out, b_out}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = M_AND;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("idle");

    do_run(M_AND,  '{pass: 1'b1, err: 3'd0, fail: 4'b0000}, 1'b0);
    do_run(M_ZERO, '{pass: 1'b0, err: 3'd1, fail: 4'b1000}, 1'b0);
    do_run(M_ONE,  '{pass: 1'b0, err: 3'd3, fail: 4'b0111}, 1'b0);
    do_run(M_OR,   '{pass: 1'b0, err: 3'd2, fail: 4'b0110}, 1'b0);

    // Abort a faulty run at cycle 7; reset must clear everything asynchronously
    mode = M_ONE;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_err", 32'(err_count), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("post_rst_idle");

    do_run(M_AND, '{pass: 1'b1, err: 3'd0, fail: 4'b0000}, 1'b0);

    // start held through a run, then still high in DONE restarts it
    do_run(M_AND, '{pass: 1'b1, err: 3'd0, fail: 4'b0000}, 1'b1);
    sb.push_back('{pass: 1'b1, err: 3'd0, fail: 4'b0000});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("restart_done", 32'(done), 32'd0);
    check("restart_pass", 32'(pass), 32'd0);
    check("restart_err", 32'(err_count), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_vec", 32'({a_out, b_out}), 32'd0);
    for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
    check("restart_done_timeout", 32'(done), 32'd1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
